branch_target_predictor: RTL and testbench

BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

---
 rtl/branch_target_predictor_pkg.sv | 17 +
 rtl/mux_2_to_1.sv | 21 ++
 rtl/branch_target_predictor.sv | 86 ++++++++
 tb/tb_branch_target_predictor.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/branch_target_predictor_pkg.sv
// ============================================================================
// Module : branch_target_predictor_pkg
// Brief  : Shared processor constants for the branch target predictor.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package branch_target_predictor_pkg;

    localparam int unsigned BTP_ADDRESS_WIDTH = 32;
    localparam int unsigned BTP_INDEX_WIDTH   = 6;
    // Word-aligned PCs: the two lowest bits never reach index or tag.
    localparam int unsigned BTP_TAG_WIDTH     = BTP_ADDRESS_WIDTH - BTP_INDEX_WIDTH - 2;

endpackage : branch_target_predictor_pkg

`default_nettype wire

// File: rtl/mux_2_to_1.sv
// ============================================================================
// Module : mux_2_to_1
// Brief  : Parameterized-width combinational 2:1 multiplexer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mux_2_to_1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] IN1,
    input  logic [WIDTH-1:0] IN2,
    input  logic             SELECT,
    output logic [WIDTH-1:0] OUT
);

    assign OUT = SELECT ? IN2 : IN1;

endmodule : mux_2_to_1

`default_nettype wire

// File: rtl/branch_target_predictor.sv
// ============================================================================
// Module : branch_target_predictor
// Brief  : Direct-mapped branch target buffer, combinational lookup, 1-cycle train.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int ADDRESS_WIDTH = BTP_ADDRESS_WIDTH,
    parameter int INDEX_WIDTH   = BTP_INDEX_WIDTH
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [ADDRESS_WIDTH-1:0] PC,
    input  logic [ADDRESS_WIDTH-1:0] PC_EXECUTION,
    input  logic [ADDRESS_WIDTH-1:0] PC_PREDICT_LEARN,
    input  logic                     PC_PREDICT_LEARN_SELECT,
    output logic [ADDRESS_WIDTH-1:0] PC_PREDICTED,
    output logic                     PC_PREDICTOR_STATUS
);

    localparam int TAG_WIDTH = ADDRESS_WIDTH - INDEX_WIDTH - 2;
    localparam int DEPTH     = 1 << INDEX_WIDTH;

    logic [DEPTH-1:0]         valid_q;
    logic [DEPTH-1:0]         valid_d;
    logic [TAG_WIDTH-1:0]     tag_q    [DEPTH];
    logic [ADDRESS_WIDTH-1:0] target_q [DEPTH];

    logic [INDEX_WIDTH-1:0]   w_rd_idx;
    logic [TAG_WIDTH-1:0]     w_rd_tag;
    logic [INDEX_WIDTH-1:0]   w_wr_idx;
    logic [TAG_WIDTH-1:0]     w_wr_tag;
    logic [ADDRESS_WIDTH-1:0] w_pc_plus4;
    logic                     w_hit;
    logic                     w_unused_exec_lsbs;

    assign w_rd_idx = PC[INDEX_WIDTH+1:2];
    assign w_rd_tag = PC[ADDRESS_WIDTH-1:INDEX_WIDTH+2];
    assign w_wr_idx = PC_EXECUTION[INDEX_WIDTH+1:2];
    assign w_wr_tag = PC_EXECUTION[ADDRESS_WIDTH-1:INDEX_WIDTH+2];
    assign w_unused_exec_lsbs = ^PC_EXECUTION[1:0];

    // Reads see the registered table only, so a same-cycle write is not bypassed.
    assign w_hit      = valid_q[w_rd_idx] && (tag_q[w_rd_idx] == w_rd_tag);
    assign w_pc_plus4 = PC + ADDRESS_WIDTH'(4);

    always_comb begin
        valid_d = valid_q;
        if (PC_PREDICT_LEARN_SELECT) begin
            valid_d[w_wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload arrays carry no reset; a cleared valid bit makes them don't-care.
    always_ff @(posedge CLK) begin
        if (PC_PREDICT_LEARN_SELECT) begin
            tag_q[w_wr_idx]    <= w_wr_tag;
            target_q[w_wr_idx] <= PC_PREDICT_LEARN;
        end
    end

    mux_2_to_1 #(
        .WIDTH (ADDRESS_WIDTH)
    ) u_next_pc_mux (
        .IN1    (w_pc_plus4),
        .IN2    (target_q[w_rd_idx]),
        .SELECT (w_hit),
        .OUT    (PC_PREDICTED)
    );

    assign PC_PREDICTOR_STATUS = w_hit;

endmodule : branch_target_predictor

`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
// ============================================================================
// Module : tb_branch_target_predictor
// Brief  : Table-driven, scoreboarded self-checking bench for the BTB.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_branch_target_predictor;

    typedef struct {
        logic        rst_n;
        logic [31:0] pc;
        logic [31:0] exec_pc;
        logic [31:0] learn;
        logic        sel;
        logic        exp_status;
        logic [31:0] exp_pred;
    } vec_t;

    typedef struct {
        logic        status;
        logic [31:0] pred;
    } exp_t;

    localparam int NV = 16;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] exec_pc;
    logic [31:0] learn;
    logic        sel;
    logic [31:0] pred;
    logic        status;

    vec_t vecs [NV];
    exp_t sb_q [$];
    int   n_cmp;
    int   n_bad;

    branch_target_predictor #(
        .ADDRESS_WIDTH (32),
        .INDEX_WIDTH   (6)
    ) dut (
        .CLK                     (clk),
        .RESET_N                 (rst_n),
        .PC                      (pc),
        .PC_EXECUTION            (exec_pc),
        .PC_PREDICT_LEARN        (learn),
        .PC_PREDICT_LEARN_SELECT (sel),
        .PC_PREDICTED            (pred),
        .PC_PREDICTOR_STATUS     (status)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push_exp(input logic st, input logic [31:0] p);
        exp_t e;
        e.status = st;
        e.pred   = p;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            n_cmp++;
            if (status !== e.status) begin
                n_bad++;
                $display("FAIL %s status: got %b expected %b", name, status, e.status);
            end
            n_cmp++;
            if (pred !== e.pred) begin
                n_bad++;
                $display("FAIL %s predicted: got %h expected %h", name, pred, e.pred);
            end
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] p, input logic [31:0] x,
                         input logic [31:0] l, input logic s);
        rst_n   = r;
        pc      = p;
        exec_pc = x;
        learn   = l;
        sel     = s;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        drive(1'b0, 32'h0000_0100, 32'h0, 32'h0, 1'b0);

        //           rst   pc            exec          learn         sel  st    pred
        vecs[0]  = '{1'b0, 32'h0000_0100, 32'h0000_0100, 32'h0000_0200, 1'b1, 1'b0, 32'h0000_0104};
        vecs[1]  = '{1'b1, 32'h0000_0100, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_0104};
        vecs[2]  = '{1'b1, 32'h0000_0100, 32'h0000_0100, 32'h0000_0200, 1'b1, 1'b0, 32'h0000_0104};
        vecs[3]  = '{1'b1, 32'h0000_0100, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_0200};
        vecs[4]  = '{1'b1, 32'h0000_0200, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_0204};
        vecs[5]  = '{1'b1, 32'h0000_0200, 32'h0000_0200, 32'h0000_0300, 1'b1, 1'b0, 32'h0000_0204};
        vecs[6]  = '{1'b1, 32'h0000_0100, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_0104};
        vecs[7]  = '{1'b1, 32'h0000_0200, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_0300};
        vecs[8]  = '{1'b1, 32'h0000_0104, 32'h0000_0104, 32'h0000_0500, 1'b1, 1'b0, 32'h0000_0108};
        vecs[9]  = '{1'b1, 32'h0000_0100, 32'h0000_0100, 32'h0000_0400, 1'b1, 1'b0, 32'h0000_0104};
        vecs[10] = '{1'b1, 32'h0000_0100, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_0400};
        vecs[11] = '{1'b1, 32'h0000_0104, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_0500};
        vecs[12] = '{1'b1, 32'h0000_0200, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_0204};
        vecs[13] = '{1'b1, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_0000};
        vecs[14] = '{1'b1, 32'h0000_0103, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_0400};
        vecs[15] = '{1'b1, 32'h0000_0140, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_0144};

        #1;
        push_exp(1'b0, 32'h0000_0104);
        pop_cmp("reset_at_time0");

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].rst_n, vecs[i].pc, vecs[i].exec_pc, vecs[i].learn, vecs[i].sel);
            push_exp(vecs[i].exp_status, vecs[i].exp_pred);
            #2;
            pop_cmp($sformatf("vec%0d", i));
        end

        // Train the top-of-address-space entry, then confirm it hits.
        @(negedge clk);
        drive(1'b1, 32'h0000_0100, 32'hFFFF_FFFC, 32'h1234_5678, 1'b1);
        @(negedge clk);
        drive(1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        push_exp(1'b1, 32'h1234_5678);
        #1;
        pop_cmp("top_entry_hit");

        // Asynchronous reset mid-cycle must clear the hit before the next edge.
        drive(1'b1, 32'h0000_0100, 32'h0, 32'h0, 1'b0);
        push_exp(1'b1, 32'h0000_0400);
        #1;
        pop_cmp("pre_async_reset");
        rst_n = 1'b0;
        push_exp(1'b0, 32'h0000_0104);
        #1;
        pop_cmp("async_reset_clears");
        pc = 32'hFFFF_FFFC;
        push_exp(1'b0, 32'h0000_0000);
        #1;
        pop_cmp("wrap_after_reset");

        // Write under reset is dropped; table stays empty after release.
        @(negedge clk);
        drive(1'b0, 32'h0000_0104, 32'h0000_0104, 32'h0000_0700, 1'b1);
        @(negedge clk);
        drive(1'b1, 32'h0000_0104, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        push_exp(1'b0, 32'h0000_0108);
        #1;
        pop_cmp("post_reset_empty");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_branch_target_predictor

`default_nettype wire
